pivota_order_dispatcher: RTL and testbench

Sequencer between a compiled Pivota strategy's order buffer (side/qty arrays, up to 256 entries) and the exchange-facing order port. On a start pulse it walks the buffer from index 0 to order_count-1, one entry at a time. It applies a net-position risk limit to each entry and issues accepted orders over a valid/ready handshake. It keeps running sent, rejected and position figures for the host.

---
 rtl/pivota_pkg.sv | 26 ++
 rtl/pivota_risk_check.sv | 53 +++++
 rtl/pivota_order_dispatcher.sv | 177 +++++++++++++++++
 tb/tb_pivota_order_dispatcher.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pivota_pkg.sv
// Shared types and defaults for the Pivota order-dispatch blocks.
package pivota_pkg;

    localparam int PV_SIDE_W  = 4;
    localparam int PV_QTY_W   = 4;
    localparam int PV_MAX_POS = 20;

    localparam int SIDE_BUY  = 1;
    localparam int SIDE_SELL = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_CHECK,
        ST_SEND,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        RSN_OK,
        RSN_BAD_SIDE,
        RSN_LIMIT
    } reason_t;

endpackage

// File: rtl/pivota_risk_check.sv
// Combinational net-position limit check for a single order entry.
module pivota_risk_check
    import pivota_pkg::*;
#(
    parameter int SIDE_W  = PV_SIDE_W,
    parameter int QTY_W   = PV_QTY_W,
    parameter int POS_W   = 16,
    parameter int MAX_POS = PV_MAX_POS
) (
    input  logic signed [POS_W-1:0]  position,
    input  logic        [SIDE_W-1:0] side,
    input  logic        [QTY_W-1:0]  qty,
    output logic signed [POS_W-1:0]  next_pos,
    output logic                     accept,
    output logic        [1:0]        reason
);

    localparam logic signed [POS_W:0] LIM = (POS_W+1)'(MAX_POS);

    logic signed [POS_W:0] w_pos_ext;
    logic signed [POS_W:0] w_qty_ext;
    logic signed [POS_W:0] w_next;
    logic                  w_accept;
    reason_t               w_reason;

    // One extra bit of headroom so the limit test cannot be fooled by overflow.
    assign w_pos_ext = {position[POS_W-1], position};
    assign w_qty_ext = {{(POS_W+1-QTY_W){1'b0}}, qty};

    always_comb begin
        w_next   = w_pos_ext;
        w_accept = 1'b0;
        w_reason = RSN_BAD_SIDE;
        if (side == SIDE_W'(SIDE_BUY)) begin
            w_next = w_pos_ext + w_qty_ext;
        end else if (side == SIDE_W'(SIDE_SELL)) begin
            w_next = w_pos_ext - w_qty_ext;
        end
        if (side == SIDE_W'(SIDE_BUY) || side == SIDE_W'(SIDE_SELL)) begin
            if (w_next > LIM || w_next < -LIM) begin
                w_reason = RSN_LIMIT;
            end else begin
                w_reason = RSN_OK;
                w_accept = 1'b1;
            end
        end
    end

    assign next_pos = w_next[POS_W-1:0];
    assign accept   = w_accept;
    assign reason   = w_reason;

endmodule

// File: rtl/pivota_order_dispatcher.sv
// Walks the strategy order buffer, risk-checks each entry and offers
// accepted orders to the exchange port over valid/ready.
module pivota_order_dispatcher
    import pivota_pkg::*;
#(
    parameter int  DEPTH   = 256,
    parameter int  SIDE_W  = PV_SIDE_W,
    parameter int  QTY_W   = PV_QTY_W,
    parameter int  POS_W   = 16,
    parameter int  MAX_POS = PV_MAX_POS,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic        [AW:0]       order_count,
    output logic        [AW-1:0]     rd_addr,
    output logic                     rd_en,
    input  logic        [SIDE_W-1:0] rd_side,
    input  logic        [QTY_W-1:0]  rd_qty,
    output logic                     ord_valid,
    output logic        [SIDE_W-1:0] ord_side,
    output logic        [QTY_W-1:0]  ord_qty,
    input  logic                     ord_ready,
    output logic                     busy,
    output logic                     done,
    output logic        [AW:0]       sent_cnt,
    output logic        [AW:0]       rej_cnt,
    output logic signed [POS_W-1:0]  position
);

    state_t                  r_state;
    logic        [AW:0]      r_cnt;
    logic        [AW-1:0]    r_idx;
    logic        [SIDE_W-1:0] r_cur_side;
    logic        [QTY_W-1:0] r_cur_qty;
    logic        [AW-1:0]    r_rd_addr;
    logic                    r_rd_en;
    logic                    r_ord_valid;
    logic        [SIDE_W-1:0] r_ord_side;
    logic        [QTY_W-1:0] r_ord_qty;
    logic                    r_busy;
    logic                    r_done;
    logic        [AW:0]      r_sent;
    logic        [AW:0]      r_rej;
    logic signed [POS_W-1:0] r_position;

    logic signed [POS_W-1:0] w_next_pos;
    logic                    w_accept;
    logic        [1:0]       w_reason;
    logic                    w_take;
    logic        [AW:0]      w_cnt_clamp;
    logic                    w_last;
    logic        [AW-1:0]    w_idx_inc;

    pivota_risk_check #(
        .SIDE_W  (SIDE_W),
        .QTY_W   (QTY_W),
        .POS_W   (POS_W),
        .MAX_POS (MAX_POS)
    ) u_risk (
        .position (r_position),
        .side     (r_cur_side),
        .qty      (r_cur_qty),
        .next_pos (w_next_pos),
        .accept   (w_accept),
        .reason   (w_reason)
    );

    assign w_take      = w_accept && (w_reason == RSN_OK);
    assign w_cnt_clamp = (order_count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : order_count;
    assign w_last      = ({1'b0, r_idx} == r_cnt - (AW+1)'(1));
    assign w_idx_inc   = r_idx + AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_cur_side  <= '0;
            r_cur_qty   <= '0;
            r_rd_addr   <= '0;
            r_rd_en     <= 1'b0;
            r_ord_valid <= 1'b0;
            r_ord_side  <= '0;
            r_ord_qty   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sent      <= '0;
            r_rej       <= '0;
            r_position  <= '0;
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt  <= w_cnt_clamp;
                        r_idx  <= '0;
                        r_sent <= '0;
                        r_rej  <= '0;
                        r_busy <= 1'b1;
                        if (w_cnt_clamp == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state   <= ST_FETCH;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= '0;
                        end
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cur_side <= rd_side;
                    r_cur_qty  <= rd_qty;
                    r_state    <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_take) begin
                        r_ord_valid <= 1'b1;
                        r_ord_side  <= r_cur_side;
                        r_ord_qty   <= r_cur_qty;
                        r_state     <= ST_SEND;
                    end else begin
                        r_rej <= r_rej + (AW+1)'(1);
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx     <= w_idx_inc;
                            r_rd_addr <= w_idx_inc;
                            r_rd_en   <= 1'b1;
                            r_state   <= ST_FETCH;
                        end
                    end
                end
                ST_SEND: begin
                    // Position and the entry are frozen here, so the risk result is still valid.
                    if (ord_ready) begin
                        r_ord_valid <= 1'b0;
                        r_sent      <= r_sent + (AW+1)'(1);
                        r_position  <= w_next_pos;
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx     <= w_idx_inc;
                            r_rd_addr <= w_idx_inc;
                            r_rd_en   <= 1'b1;
                            r_state   <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_addr   = r_rd_addr;
    assign rd_en     = r_rd_en;
    assign ord_valid = r_ord_valid;
    assign ord_side  = r_ord_side;
    assign ord_qty   = r_ord_qty;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sent_cnt  = r_sent;
    assign rej_cnt   = r_rej;
    assign position  = r_position;

endmodule

// File: tb/tb_pivota_order_dispatcher.sv
// Bench: two dispatchers (limit 20 and limit 16) share stimulus; a sweep-level
// model predicts reads, offers, counters and position for each.
module tb_pivota_order_dispatcher;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  order_count;
    logic        ord_ready;

    logic [7:0]         rd_addr   [2];
    logic               rd_en     [2];
    logic               ord_valid [2];
    logic [3:0]         ord_side  [2];
    logic [3:0]         ord_qty   [2];
    logic               busy      [2];
    logic               done      [2];
    logic [8:0]         sent_cnt  [2];
    logic [8:0]         rej_cnt   [2];
    logic signed [15:0] position  [2];

    logic [3:0] mem_side [256];
    logic [3:0] mem_qty  [256];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;
    int rdy_mode = 0;   // 0: ready high, 1: ready low, 2: five-cycle stall per offer
    int wcnt     = 0;

    // model state per instance
    bit m_active [2];
    int m_pos    [2];
    int m_final  [2];
    int m_cnt    [2];
    int m_rd     [2];
    int m_sent   [2];
    int m_rej    [2];
    int m_popped [2];
    int q_side   [2][256];
    int q_qty    [2][256];
    int q_pos    [2][256];
    int q_n      [2];
    int q_h      [2];
    bit pend     [2];
    int lat      [2];
    int last_lat [2];
    int ndone    [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ord_ready = (rdy_mode == 0) ? 1'b1 : ((rdy_mode == 2) ? (wcnt == 5) : 1'b0);

    always @(posedge clk) begin
        if (rdy_mode == 2 && (ord_valid[0] || ord_valid[1])) wcnt <= (wcnt == 5) ? 0 : wcnt + 1;
        else wcnt <= 0;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [3:0] b_side;
        logic [3:0] b_qty;
        always @(posedge clk) begin
            if (rd_en[gi]) begin
                b_side <= mem_side[rd_addr[gi]];
                b_qty  <= mem_qty[rd_addr[gi]];
            end
        end
        pivota_order_dispatcher #(.MAX_POS(gi == 0 ? 20 : 16)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start),
            .order_count (order_count),
            .rd_addr     (rd_addr[gi]),
            .rd_en       (rd_en[gi]),
            .rd_side     (b_side),
            .rd_qty      (b_qty),
            .ord_valid   (ord_valid[gi]),
            .ord_side    (ord_side[gi]),
            .ord_qty     (ord_qty[gi]),
            .ord_ready   (ord_ready),
            .busy        (busy[gi]),
            .done        (done[gi]),
            .sent_cnt    (sent_cnt[gi]),
            .rej_cnt     (rej_cnt[gi]),
            .position    (position[gi])
        );
    end

    function automatic string nm(input string s, input int i);
        return $sformatf("%s[%0d]", s, i);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-sweep prediction straight from the risk rules.
    task automatic model_start(input int i);
        int cnt, p, np, s, q, lim;
        lim = (i == 0) ? 20 : 16;
        cnt = (int'(order_count) > 256) ? 256 : int'(order_count);
        m_cnt[i] = cnt; m_rd[i] = 0; q_n[i] = 0; q_h[i] = 0;
        m_sent[i] = 0; m_rej[i] = 0; m_popped[i] = 0; lat[i] = 0;
        p = m_pos[i];
        for (int k = 0; k < cnt; k++) begin
            s = int'(mem_side[k]);
            q = int'(mem_qty[k]);
            np = (s == 1) ? p + q : p - q;
            if ((s != 1 && s != 2) || np > lim || np < -lim) begin
                m_rej[i]++;
            end else begin
                q_side[i][q_n[i]] = s;
                q_qty[i][q_n[i]]  = q;
                q_pos[i][q_n[i]]  = np;
                q_n[i]++;
                m_sent[i]++;
                p = np;
            end
        end
        m_final[i]  = p;
        m_active[i] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk(nm("position", i), int'(position[i]), m_pos[i]);
                chk(nm("sent_cnt", i), int'(sent_cnt[i]), m_popped[i]);
                if (m_active[i] && m_rd[i] < m_cnt[i]) begin
                    if (rd_en[i]) begin
                        chk(nm("rd_addr", i), int'(rd_addr[i]), m_rd[i]);
                        m_rd[i]++;
                    end
                end else begin
                    chk(nm("rd_en_idle", i), int'(rd_en[i]), 0);
                end
                if (pend[i]) chk(nm("ord_valid_hold", i), int'(ord_valid[i]), 1);
                if (q_h[i] < q_n[i]) begin
                    if (ord_valid[i]) begin
                        chk(nm("ord_side", i), int'(ord_side[i]), q_side[i][q_h[i]]);
                        chk(nm("ord_qty", i), int'(ord_qty[i]), q_qty[i][q_h[i]]);
                        if (ord_ready && !rst) begin
                            $display("inst%0d order sent: side=%0d qty=%0d pos->%0d",
                                     i, ord_side[i], ord_qty[i], q_pos[i][q_h[i]]);
                            m_pos[i] = q_pos[i][q_h[i]];
                            q_h[i]++;
                            m_popped[i]++;
                        end
                    end
                end else begin
                    chk(nm("ord_valid_idle", i), int'(ord_valid[i]), 0);
                end
                pend[i] = ord_valid[i] && !ord_ready;
                if (m_active[i]) begin
                    lat[i]++;
                    if (done[i]) begin
                        chk(nm("done_sent", i), int'(sent_cnt[i]), m_sent[i]);
                        chk(nm("done_rej", i), int'(rej_cnt[i]), m_rej[i]);
                        chk(nm("done_reads", i), m_rd[i], m_cnt[i]);
                        chk(nm("done_offers_left", i), q_n[i] - q_h[i], 0);
                        $display("inst%0d sweep done: sent=%0d rej=%0d pos=%0d cycles=%0d",
                                 i, sent_cnt[i], rej_cnt[i], position[i], lat[i]);
                        ndone[i]++;
                        last_lat[i] = lat[i];
                        m_active[i] = 1'b0;
                    end
                end else begin
                    chk(nm("done_idle", i), int'(done[i]), 0);
                end
                chk(nm("busy", i), int'(busy[i]), int'(m_active[i]));
                if (rst) begin
                    m_active[i] = 1'b0; m_pos[i] = 0; m_popped[i] = 0;
                    q_n[i] = 0; q_h[i] = 0; pend[i] = 1'b0;
                end else if (start && !m_active[i]) begin
                    model_start(i);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int cnt);
        order_count = 9'(cnt);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_active[0] || m_active[1]) && n < budget) begin
            tick(1);
            n++;
        end
        chk("sweep_timeout", int'(m_active[0] || m_active[1]), 0);
    endtask

    task automatic set_entry(input int k, input int s, input int q);
        mem_side[k] = 4'(s);
        mem_qty[k]  = 4'(q);
    endtask

    initial begin
        int saved_done;
        int n;
        rst = 1'b1; start = 1'b0; order_count = '0;
        for (int k = 0; k < 256; k++) set_entry(k, 0, 0);
        tick(2);
        for (int i = 0; i < 2; i++) begin
            chk(nm("rst_rd_addr", i), int'(rd_addr[i]), 0);
            chk(nm("rst_rd_en", i), int'(rd_en[i]), 0);
            chk(nm("rst_ord_valid", i), int'(ord_valid[i]), 0);
            chk(nm("rst_ord_side", i), int'(ord_side[i]), 0);
            chk(nm("rst_ord_qty", i), int'(ord_qty[i]), 0);
            chk(nm("rst_busy", i), int'(busy[i]), 0);
            chk(nm("rst_done", i), int'(done[i]), 0);
            chk(nm("rst_rej", i), int'(rej_cnt[i]), 0);
            chk(nm("rst_position", i), int'(position[i]), 0);
        end
        chk_en = 1'b1;
        rst = 1'b0;
        tick(1);

        // four buys, ready high
        set_entry(0, 1, 15); set_entry(1, 1, 1); set_entry(2, 1, 1); set_entry(3, 1, 1);
        rdy_mode = 0;
        pulse_start(4);
        wait_idle(2000);
        chk("t1_model_pos0", m_final[0], 18);
        chk("t1_model_pos1", m_final[1], 16);
        chk("t1_pos0", int'(position[0]), 18);
        chk("t1_sent0", int'(sent_cnt[0]), 4);
        chk("t1_rej0", int'(rej_cnt[0]), 0);
        chk("t1_cycles0", last_lat[0], 18);
        chk("t1_dones0", ndone[0], 1);
        chk("t1_pos1", int'(position[1]), 16);
        chk("t1_sent1", int'(sent_cnt[1]), 2);
        chk("t1_rej1", int'(rej_cnt[1]), 2);
        chk("t1_cycles1", last_lat[1], 16);

        // single sell carried from previous position; second start mid-sweep ignored
        set_entry(0, 2, 3);
        order_count = 9'd1;
        start = 1'b1;
        tick(1);
        start = 1'b0; order_count = 9'd4;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle(2000);
        chk("t6_pos0", int'(position[0]), 15);
        chk("t6_pos1", int'(position[1]), 13);
        chk("t6_sent0", int'(sent_cnt[0]), 1);
        chk("t6_rej0", int'(rej_cnt[0]), 0);
        chk("t6_dones0", ndone[0], 2);

        // reset while waiting in SEND
        set_entry(0, 1, 2); set_entry(1, 2, 2);
        rdy_mode = 1;
        pulse_start(2);
        n = 0;
        while (!ord_valid[0] && n < 50) begin
            tick(1);
            n++;
        end
        chk("t5_offer_seen", int'(ord_valid[0]), 1);
        tick(2);
        saved_done = ndone[0];
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk(nm("t5_valid", i), int'(ord_valid[i]), 0);
            chk(nm("t5_pos", i), int'(position[i]), 0);
            chk(nm("t5_busy", i), int'(busy[i]), 0);
        end
        tick(2);
        chk("t5_no_done", ndone[0], saved_done);
        rdy_mode = 0;
        pulse_start(2);
        wait_idle(2000);
        chk("t5_clean_sent", int'(sent_cnt[0]), 2);
        chk("t5_clean_pos", int'(position[0]), 0);

        // sells with stalled ready, two invalid sides
        for (int k = 0; k < 4; k++) set_entry(k, 2, 4);
        set_entry(4, 3, 5); set_entry(5, 0, 2);
        rdy_mode = 2;
        pulse_start(6);
        wait_idle(4000);
        rdy_mode = 0;
        for (int i = 0; i < 2; i++) begin
            chk(nm("t3_pos", i), int'(position[i]), -16);
            chk(nm("t3_sent", i), int'(sent_cnt[i]), 4);
            chk(nm("t3_rej", i), int'(rej_cnt[i]), 2);
        end

        // empty sweep
        pulse_start(0);
        wait_idle(100);
        chk("t4_cycles", last_lat[0], 2);
        chk("t4_reads", m_rd[0], 0);
        chk("t4_sent", int'(sent_cnt[0]), 0);
        chk("t4_rej", int'(rej_cnt[0]), 0);

        // count above DEPTH clamps to 256 entries, all invalid
        for (int k = 0; k < 256; k++) set_entry(k, 0, 1);
        pulse_start(300);
        wait_idle(3000);
        chk("t7_rej", int'(rej_cnt[0]), 256);
        chk("t7_reads", m_rd[0], 256);
        chk("t7_cycles", last_lat[0], 770);
        chk("t7_pos", int'(position[1]), -16);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
